// File: rtl/direct_mapped_cache_pkg.sv
// Shared definitions for the direct-mapped cache: default geometry,
// controller state encoding and address-field width helpers.
package direct_mapped_cache_pkg;

  localparam int DEF_WORD_SIZE  = 16;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_NUM_LINES  = 4;

  // Controller states; encodings are fixed so traces match the datapath docs.
  typedef enum logic [1:0] {
    CACHE_IDLE  = 2'd0,
    CACHE_FILL  = 2'd1,
    CACHE_WRITE = 2'd2,
    CACHE_WDONE = 2'd3
  } cache_state_e;

  // Number of address bits below the index field.
  function automatic int offset_width(input int line_words);
    return $clog2(line_words);
  endfunction

  // Number of address bits that select a line.
  function automatic int index_width(input int num_lines);
    return $clog2(num_lines);
  endfunction

  // Remaining upper address bits stored as the tag.
  function automatic int tag_width(input int word_size, input int line_words, input int num_lines);
    return word_size - $clog2(line_words) - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/direct_mapped_cache_if.sv
// CPU-side request/response and memory-side fill/write-through signals of
// one cache instance. The slave modport is the cache's view; the master
// modport is the combined datapath + main-memory view.
interface direct_mapped_cache_if
  import direct_mapped_cache_pkg::*;
#(
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int LINE_WORDS = DEF_LINE_WORDS
);

  logic                            cpu_read;
  logic                            cpu_write;
  logic [WORD_SIZE-1:0]            cpu_address;
  logic [WORD_SIZE-1:0]            cpu_wdata;
  logic [WORD_SIZE-1:0]            cpu_rdata;
  logic                            hit;
  logic                            mem_read;
  logic                            mem_write;
  logic [WORD_SIZE-1:0]            mem_address;
  logic [WORD_SIZE-1:0]            mem_wdata;
  logic [WORD_SIZE*LINE_WORDS-1:0] mem_rdata;
  logic                            mem_ready;

  modport slave (
    input  cpu_read, cpu_write, cpu_address, cpu_wdata, mem_rdata, mem_ready,
    output cpu_rdata, hit, mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output cpu_read, cpu_write, cpu_address, cpu_wdata, mem_rdata, mem_ready,
    input  cpu_rdata, hit, mem_read, mem_write, mem_address, mem_wdata
  );

endinterface

// File: rtl/direct_mapped_cache_line_store.sv
// Valid/tag/data storage for the direct-mapped cache. One combinational
// read port, a whole-line write port (fill) and a single-word write port
// (write-through hit update). Only the valid bits are reset; data and tags
// are never observed while their line is invalid.
module cache_line_store
  import direct_mapped_cache_pkg::*;
#(
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int NUM_LINES  = DEF_NUM_LINES,
  parameter int OFFSET_W   = offset_width(LINE_WORDS),
  parameter int INDEX_W    = index_width(NUM_LINES),
  parameter int TAG_W      = tag_width(WORD_SIZE, LINE_WORDS, NUM_LINES)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [INDEX_W-1:0]              rd_index,
  input  logic [OFFSET_W-1:0]             rd_offset,
  output logic                            rd_valid,
  output logic [TAG_W-1:0]                rd_tag,
  output logic [WORD_SIZE-1:0]            rd_word,
  input  logic                            line_we,
  input  logic [INDEX_W-1:0]              line_index,
  input  logic [TAG_W-1:0]                line_tag,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] line_data,
  input  logic                            word_we,
  input  logic [INDEX_W-1:0]              word_index,
  input  logic [OFFSET_W-1:0]             word_offset,
  input  logic [WORD_SIZE-1:0]            word_data
);

  logic [NUM_LINES-1:0] valid_r;
  logic [TAG_W-1:0]     tag_r  [NUM_LINES];
  logic [WORD_SIZE-1:0] data_r [NUM_LINES][LINE_WORDS];

  assign rd_valid = valid_r[rd_index];
  assign rd_tag   = tag_r[rd_index];
  assign rd_word  = data_r[rd_index][rd_offset];

  // Valid bits: cleared by reset, set when a fill installs a line.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_r <= '0;
    end else if (line_we) begin
      valid_r[line_index] <= 1'b1;
    end
  end

  // Tag and data: a fill overwrites the whole line, a write hit patches one word.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_r[line_index] <= line_tag;
      for (int w = 0; w < LINE_WORDS; w++) begin
        data_r[line_index][w] <= line_data[w*WORD_SIZE +: WORD_SIZE];
      end
    end else if (word_we) begin
      data_r[word_index][word_offset] <= word_data;
    end
  end

endmodule

// File: rtl/direct_mapped_cache.sv
// Direct-mapped, read-allocate, write-through cache between one datapath
// memory port and main memory. hit=0 stalls the datapath. Reads that hit
// complete in the same cycle; misses fill a whole line; every write is sent
// to memory and patches the cached word only if that line is resident.
// Optional statistics counters are enabled with the CACHE_STATS_EN macro.
module direct_mapped_cache
  import direct_mapped_cache_pkg::*;
#(
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int NUM_LINES  = DEF_NUM_LINES
) (
  input  logic                 clk,
  input  logic                 reset_n,
  direct_mapped_cache_if.slave bus,
  output logic [WORD_SIZE-1:0] hit_count,
  output logic [WORD_SIZE-1:0] miss_count
);

  localparam int OFFSET_W = offset_width(LINE_WORDS);
  localparam int INDEX_W  = index_width(NUM_LINES);
  localparam int TAG_W    = tag_width(WORD_SIZE, LINE_WORDS, NUM_LINES);

  cache_state_e         state_r;
  logic                 mem_read_r;
  logic                 mem_write_r;
  logic [WORD_SIZE-1:0] lat_addr_r;
  logic [WORD_SIZE-1:0] lat_wdata_r;

  logic [TAG_W-1:0]     cpu_tag_s, lat_tag_s, look_tag_s, rd_tag_s;
  logic [INDEX_W-1:0]   cpu_index_s, lat_index_s, look_index_s;
  logic [OFFSET_W-1:0]  cpu_offset_s, lat_offset_s, look_offset_s;
  logic                 rd_valid_s;
  logic [WORD_SIZE-1:0] rd_word_s;
  logic                 tag_match_s;
  logic                 req_read_s;
  logic                 req_write_s;
  logic                 hit_s;
  logic [WORD_SIZE-1:0] rdata_s;
  logic                 line_we_s;
  logic                 word_we_s;

  assign cpu_tag_s    = bus.cpu_address[WORD_SIZE-1 -: TAG_W];
  assign cpu_index_s  = bus.cpu_address[OFFSET_W +: INDEX_W];
  assign cpu_offset_s = bus.cpu_address[OFFSET_W-1:0];
  assign lat_tag_s    = lat_addr_r[WORD_SIZE-1 -: TAG_W];
  assign lat_index_s  = lat_addr_r[OFFSET_W +: INDEX_W];
  assign lat_offset_s = lat_addr_r[OFFSET_W-1:0];

  // A simultaneous read and write is handled as a write.
  assign req_write_s = bus.cpu_write;
  assign req_read_s  = bus.cpu_read & ~bus.cpu_write;

  // Look up the live CPU address while idle, otherwise the latched request
  // (needed to decide whether a write-through also patches the line).
  always_comb begin
    look_tag_s    = cpu_tag_s;
    look_index_s  = cpu_index_s;
    look_offset_s = cpu_offset_s;
    if (state_r == CACHE_IDLE) begin
      look_tag_s    = cpu_tag_s;
      look_index_s  = cpu_index_s;
      look_offset_s = cpu_offset_s;
    end else begin
      look_tag_s    = lat_tag_s;
      look_index_s  = lat_index_s;
      look_offset_s = lat_offset_s;
    end
  end

  assign tag_match_s = rd_valid_s & (rd_tag_s == look_tag_s);

  // Gate store writes with reset so a memory response racing reset is dropped.
  assign line_we_s = reset_n & (state_r == CACHE_FILL)  & bus.mem_ready;
  assign word_we_s = reset_n & (state_r == CACHE_WRITE) & bus.mem_ready & tag_match_s;

  cache_line_store #(
    .WORD_SIZE  (WORD_SIZE),
    .LINE_WORDS (LINE_WORDS),
    .NUM_LINES  (NUM_LINES),
    .OFFSET_W   (OFFSET_W),
    .INDEX_W    (INDEX_W),
    .TAG_W      (TAG_W)
  ) u_store (
    .clk         (clk),
    .reset_n     (reset_n),
    .rd_index    (look_index_s),
    .rd_offset   (look_offset_s),
    .rd_valid    (rd_valid_s),
    .rd_tag      (rd_tag_s),
    .rd_word     (rd_word_s),
    .line_we     (line_we_s),
    .line_index  (lat_index_s),
    .line_tag    (lat_tag_s),
    .line_data   (bus.mem_rdata),
    .word_we     (word_we_s),
    .word_index  (lat_index_s),
    .word_offset (lat_offset_s),
    .word_data   (lat_wdata_r)
  );

  // Stall/response decode: same-cycle hit on idle reads, stall while memory
  // is busy, one release cycle after a write; forced idle-looking in reset.
  always_comb begin
    hit_s   = 1'b1;
    rdata_s = '0;
    if (!reset_n) begin
      hit_s   = 1'b1;
      rdata_s = '0;
    end else begin
      // Invalid lines read as zero so uninitialised storage never escapes.
      rdata_s = rd_valid_s ? rd_word_s : '0;
      case (state_r)
        CACHE_IDLE: begin
          if (req_write_s) begin
            hit_s = 1'b0;
          end else if (req_read_s) begin
            hit_s = tag_match_s;
          end else begin
            hit_s = 1'b1;
          end
        end
        CACHE_FILL:  hit_s = 1'b0;
        CACHE_WRITE: hit_s = 1'b0;
        CACHE_WDONE: hit_s = 1'b1;
        default:     hit_s = 1'b1;
      endcase
    end
  end

  // Controller: launches fills and write-throughs, waits for mem_ready.
  // A fill is never aborted by an address change; the new address is
  // simply looked up again once the line is installed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= CACHE_IDLE;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      lat_addr_r  <= '0;
      lat_wdata_r <= '0;
    end else begin
      case (state_r)
        CACHE_IDLE: begin
          if (req_write_s) begin
            state_r     <= CACHE_WRITE;
            mem_write_r <= 1'b1;
            lat_addr_r  <= bus.cpu_address;
            lat_wdata_r <= bus.cpu_wdata;
          end else if (req_read_s && !tag_match_s) begin
            state_r    <= CACHE_FILL;
            mem_read_r <= 1'b1;
            lat_addr_r <= {cpu_tag_s, cpu_index_s, {OFFSET_W{1'b0}}};
          end
        end
        CACHE_FILL: begin
          if (bus.mem_ready) begin
            state_r    <= CACHE_IDLE;
            mem_read_r <= 1'b0;
          end
        end
        CACHE_WRITE: begin
          if (bus.mem_ready) begin
            state_r     <= CACHE_WDONE;
            mem_write_r <= 1'b0;
          end
        end
        CACHE_WDONE: begin
          state_r <= CACHE_IDLE;
        end
        default: begin
          state_r     <= CACHE_IDLE;
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hit         = hit_s;
  assign bus.cpu_rdata   = rdata_s;
  assign bus.mem_read    = mem_read_r;
  assign bus.mem_write   = mem_write_r;
  assign bus.mem_address = lat_addr_r;
  assign bus.mem_wdata   = lat_wdata_r;

`ifdef CACHE_STATS_EN
  logic [WORD_SIZE-1:0] hit_cnt_r;
  logic [WORD_SIZE-1:0] miss_cnt_r;

  function automatic logic [WORD_SIZE-1:0] sat_inc(input logic [WORD_SIZE-1:0] v);
    return (&v) ? v : v + WORD_SIZE'(1);
  endfunction

  // Saturating statistics: idle read hits, and every idle-to-memory transition.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit_cnt_r  <= '0;
      miss_cnt_r <= '0;
    end else if (state_r == CACHE_IDLE) begin
      if (req_read_s && tag_match_s) begin
        hit_cnt_r <= sat_inc(hit_cnt_r);
      end
      if (req_write_s || (req_read_s && !tag_match_s)) begin
        miss_cnt_r <= sat_inc(miss_cnt_r);
      end
    end
  end

  assign hit_count  = hit_cnt_r;
  assign miss_count = miss_cnt_r;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: doc/direct_mapped_cache.md
Name: direct_mapped_cache

Overview:
- Direct-mapped, read-allocate, write-through cache between one datapath memory port (IF: readM1/address1/data1, or MEM: readM2/writeM2/address2/data2) and main memory.
- Generates the `hit` signal the datapath uses as its stall source (`hit`=0 stalls the pipeline).
- Two instances are planned: I-cache (cpu_write tied 0) and D-cache.
- Main memory delivers a whole line per read and accepts one word per write, both with variable latency signalled by mem_ready.

Parameters:
- WORD_SIZE, 16, data/address width.
- LINE_WORDS, 4, words per line; power of two.
- NUM_LINES, 4, number of lines; power of two.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- cpu_read  in  1  read request; held by datapath until hit=1.
- cpu_write  in  1  write request; held until hit=1.
- cpu_address  in  WORD_SIZE  word address.
- cpu_wdata  in  WORD_SIZE  write data.
- cpu_rdata  out  WORD_SIZE  read data; valid when hit=1 and cpu_read.
- hit  out  1  request satisfied this cycle; 1 when no request.
- mem_read  out  1  line fill request.
- mem_write  out  1  word write-through request.
- mem_address  out  WORD_SIZE  line-aligned for fill, word address for write.
- mem_wdata  out  WORD_SIZE  write-through data.
- mem_rdata  in  WORD_SIZE*LINE_WORDS  fill line, word 0 in LSBs.
- mem_ready  in  1  one-cycle pulse; fill data valid / write accepted.
- hit_count  out  WORD_SIZE  statistics (see Optional Feature).
- miss_count  out  WORD_SIZE  statistics (see Optional Feature).

Behaviour:
- Address split: offset = addr[log2(LINE_WORDS)-1:0]; index = next log2(NUM_LINES) bits; tag = remaining upper bits. With defaults: tag[15:4], index[3:2], offset[1:0].
- Storage per line: valid bit, tag, and LINE_WORDS data words.
- Lookup is combinational on cpu_address in state IDLE. tag_match = valid[index] && tag equal.
- Priority: cpu_read && cpu_write together is treated as a write.
- FSM states: IDLE, FILL, WRITE, WDONE.
- IDLE:
  - Read with tag_match: hit=1, cpu_rdata = line[index].word[offset], same cycle (0-cycle latency). Stay IDLE.
  - Read miss: hit=0 → FILL.
  - Write: hit=0 → WRITE. Every write misses for at least 2 cycles.
  - No request: hit=1.
- FILL:
  - Outputs: mem_read=1, mem_address={tag,index,offset=0}, latched at the IDLE→FILL transition. hit=0.
  - On mem_ready: write mem_rdata into line[index], set tag, valid=1 → IDLE.
  - The next cycle re-looks-up and hits. Minimum read-miss penalty is 2 cycles plus memory latency.
- WRITE:
  - Outputs: mem_write=1, mem_address/mem_wdata latched from cpu_*. hit=0.
  - On mem_ready: if the latched address tag-matches, update that word in the line (no allocate on write miss) → WDONE.
- WDONE: hit=1 for exactly one cycle → IDLE.
- mem_read and mem_write are never both 1.
- Address changes during FILL (e.g. an IF flush redirecting PC): the fill is not aborted; the line is installed, then the new address is looked up in IDLE.
- cpu_rdata when hit=0: returns the indexed word. The value is don't-care but must not be X after reset.
- Reset (any cycle, including mid-FILL/WRITE): state=IDLE, all valid=0, mem_read=mem_write=0, counters=0, hit=1, cpu_rdata=0.
  - A mem_ready arriving after reset is ignored.
  - An interrupted write-through is lost.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined: hit_count increments in each IDLE cycle with a read that tag-matches. miss_count increments on each IDLE→FILL or IDLE→WRITE transition. Both saturate at 16'hFFFF.
- Undefined: both outputs are constant 0 and no counter flops are synthesised.

Decomposition:
- Shared header cache_defs.v, `include`d like opcodes.v, holds:
  - state encodings CACHE_IDLE=2'd0, CACHE_FILL=2'd1, CACHE_WRITE=2'd2, CACHE_WDONE=2'd3;
  - default LINE_WORDS/NUM_LINES;
  - derived field widths.
- One natural sub-module: cache_line_store. It holds the valid/tag/data arrays, with a combinational read port, a line-write port and a word-write port. The FSM and counters stay in direct_mapped_cache.

Test Plan:
- Cold read: after reset, read 16'h0025 with memory latency 3 and line {16'h1111,16'h2222,16'h3333,16'h4444} → hit=0 for 5 cycles, mem_address=16'h0024, then hit=1 with cpu_rdata=16'h2222. Next read 16'h0027 hits at 0 latency with 16'h4444.
- Conflict: fill 16'h0024, then read 16'h0124 (same index, different tag) → miss, refill, old line evicted. Re-read 16'h0024 → miss again.
- Write-through hit: after filling 16'h0024, write 16'hBEEF to 16'h0026 → mem_write=1, mem_address=16'h0026, hit=1 only in WDONE. Subsequent read of 16'h0026 hits with 16'hBEEF.
- Write miss: write 16'hCAFE to 16'h0300 (not cached) → memory written, valid bits unchanged. Read of 16'h0300 misses.
- Redirect and reset: change cpu_address mid-FILL → original line still installed, then new address serviced. Assert reset_n=0 mid-FILL → next cycle mem_read=0 and hit=1; a late mem_ready does not set valid.
- With CACHE_STATS_EN defined, after the first scenario sequence: hit_count=2, miss_count=1. Force 65536 hits → hit_count holds at 16'hFFFF.
